// File: rtl/phy_rx_sync_ctrl.sv
// Two-lane receive synchronizer in the clk_8f bit domain: per-lane MSB-first
// deserialization, comma search, byte alignment, lock sequencing and byte output.

module phy_rx_sync_lane #(
  parameter logic [7:0]  COMMA   = 8'hBC,
  parameter int unsigned BC_LOCK = 4
) (
  input  logic       clk_8f,
  input  logic       reset,
  input  logic       enable,
  input  logic       in_bit,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       sync,
  output logic       sync_nxt_c
);

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned BIT_W  = 3;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned SHR_W  = BYTE_W - 1;
  localparam logic [CNT_W-1:0] LOCK_CNT = CNT_W'(BC_LOCK);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(BYTE_W - 1);

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_ALIGN  = 2'd1,
    ST_ACTIVE = 2'd2
  } state_t;

  state_t              state, state_nxt;
  // Only the low seven bits of the previous window are ever observed, so the
  // shift register keeps just those; the window supplies the eighth bit live.
  logic [SHR_W-1:0]    shreg, shreg_nxt;
  logic [BIT_W-1:0]    bit_cnt, bit_cnt_nxt;
  logic [CNT_W-1:0]    bc_cnt, bc_cnt_nxt;
  logic [BYTE_W-1:0]   data_nxt;
  logic                valid_nxt;

  logic [BYTE_W-1:0]   win_c;
  logic                comma_c;
  logic                boundary_c;
  logic [CNT_W-1:0]    bc_inc_c;

  assign win_c      = {shreg, in_bit};
  assign comma_c    = (win_c == COMMA);
  assign boundary_c = (state != ST_SEARCH) && (bit_cnt == LAST_BIT);
  assign bc_inc_c   = bc_cnt + CNT_W'(1);
  assign sync_nxt_c = (state_nxt == ST_ACTIVE);

  // State and datapath registers
  always_ff @(posedge clk_8f or posedge reset) begin
    if (reset) begin
      state     <= ST_SEARCH;
      shreg     <= '0;
      bit_cnt   <= '0;
      bc_cnt    <= '0;
      data_out  <= '0;
      valid_out <= 1'b0;
      sync      <= 1'b0;
    end else begin
      state     <= state_nxt;
      shreg     <= shreg_nxt;
      bit_cnt   <= bit_cnt_nxt;
      bc_cnt    <= bc_cnt_nxt;
      data_out  <= data_nxt;
      valid_out <= valid_nxt;
      sync      <= sync_nxt_c;
    end
  end

  // Next-state: comma search, alignment counting, byte capture
  always_comb begin
    state_nxt   = state;
    shreg_nxt   = shreg;
    bit_cnt_nxt = bit_cnt;
    bc_cnt_nxt  = bc_cnt;
    data_nxt    = data_out;
    valid_nxt   = valid_out;

    if (!enable) begin
      // A boundary landing on this edge is dropped along with the lock.
      state_nxt   = ST_SEARCH;
      bit_cnt_nxt = '0;
      bc_cnt_nxt  = '0;
      valid_nxt   = 1'b0;
    end else begin
      shreg_nxt = win_c[SHR_W-1:0];
      if (state != ST_SEARCH) begin
        bit_cnt_nxt = bit_cnt + BIT_W'(1);
      end
      case (state)
        ST_SEARCH: begin
          valid_nxt = 1'b0;
          if (comma_c) begin
            bit_cnt_nxt = '0;
            bc_cnt_nxt  = CNT_W'(1);
            state_nxt   = ST_ALIGN;
          end
        end
        ST_ALIGN: begin
          valid_nxt = 1'b0;
          if (boundary_c) begin
            if (comma_c) begin
              bc_cnt_nxt = bc_inc_c;
              if (bc_inc_c == LOCK_CNT) begin
                state_nxt = ST_ACTIVE;
              end
            end else begin
              bc_cnt_nxt = '0;
              state_nxt  = ST_SEARCH;
            end
          end
        end
        ST_ACTIVE: begin
          if (boundary_c) begin
            data_nxt  = win_c;
            valid_nxt = !comma_c;
          end
        end
        default: begin
          state_nxt = ST_SEARCH;
          valid_nxt = 1'b0;
        end
      endcase
    end
  end

endmodule

module phy_rx_sync_ctrl #(
  parameter logic [7:0]  COMMA   = 8'hBC,
  parameter int unsigned BC_LOCK = 4
) (
  input  logic       clk_8f,
  input  logic       reset,
  input  logic       enable,
  input  logic       in_0,
  input  logic       in_1,
  output logic [7:0] data_out_0,
  output logic [7:0] data_out_1,
  output logic       valid_out_0,
  output logic       valid_out_1,
  output logic       sync_0,
  output logic       sync_1,
  output logic       active
);

  logic sync_nxt_0_c;
  logic sync_nxt_1_c;

  phy_rx_sync_lane #(
    .COMMA   (COMMA),
    .BC_LOCK (BC_LOCK)
  ) u_lane_0 (
    .clk_8f     (clk_8f),
    .reset      (reset),
    .enable     (enable),
    .in_bit     (in_0),
    .data_out   (data_out_0),
    .valid_out  (valid_out_0),
    .sync       (sync_0),
    .sync_nxt_c (sync_nxt_0_c)
  );

  phy_rx_sync_lane #(
    .COMMA   (COMMA),
    .BC_LOCK (BC_LOCK)
  ) u_lane_1 (
    .clk_8f     (clk_8f),
    .reset      (reset),
    .enable     (enable),
    .in_bit     (in_1),
    .data_out   (data_out_1),
    .valid_out  (valid_out_1),
    .sync       (sync_1),
    .sync_nxt_c (sync_nxt_1_c)
  );

  // Registered from the lanes' next state so it tracks sync_0 & sync_1 exactly
  always_ff @(posedge clk_8f or posedge reset) begin
    if (reset) begin
      active <= 1'b0;
    end else begin
      active <= sync_nxt_0_c & sync_nxt_1_c;
    end
  end

endmodule

// File: tb/tb_phy_rx_sync_ctrl.sv
// Scoreboard bench for phy_rx_sync_ctrl: directed bit streams push expected
// output snapshots keyed by clock edge; a negedge monitor pops and compares.

module tb_phy_rx_sync_ctrl;

  logic       clk_8f = 1'b0;
  logic       reset;
  logic       enable;
  logic       in_0;
  logic       in_1;
  logic [7:0] data_out_0;
  logic [7:0] data_out_1;
  logic       valid_out_0;
  logic       valid_out_1;
  logic       sync_0;
  logic       sync_1;
  logic       active;

  phy_rx_sync_ctrl #(
    .COMMA   (8'hBC),
    .BC_LOCK (4)
  ) dut (
    .clk_8f      (clk_8f),
    .reset       (reset),
    .enable      (enable),
    .in_0        (in_0),
    .in_1        (in_1),
    .data_out_0  (data_out_0),
    .data_out_1  (data_out_1),
    .valid_out_0 (valid_out_0),
    .valid_out_1 (valid_out_1),
    .sync_0      (sync_0),
    .sync_1      (sync_1),
    .active      (active)
  );

  typedef struct {
    int          when;
    string       name;
    logic [20:0] exp;
  } exp_t;

  exp_t        sb[$];
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;
  logic [20:0] mon_got;
  exp_t        mon_x;

  localparam logic [20:0] ZERO = 21'h0;

  always #5 clk_8f = ~clk_8f;

  always @(posedge clk_8f) cyc <= cyc + 1;

  // Snapshot layout: {data_out_0, data_out_1, valid_out_0, valid_out_1, sync_0, sync_1, active}
  function automatic logic [20:0] vec(input logic [7:0] d0, input logic [7:0] d1,
                                      input logic [4:0] flags);
    return {d0, d1, flags};
  endfunction

  task automatic expect_at(input int when, input string name, input logic [20:0] e);
    exp_t x;
    x.when = when;
    x.name = name;
    x.exp  = e;
    sb.push_back(x);
  endtask

  // Monitor: after each rising edge settles, compare every snapshot due by now
  always @(negedge clk_8f) begin
    mon_got = {data_out_0, data_out_1, valid_out_0, valid_out_1, sync_0, sync_1, active};
    while (sb.size() > 0 && sb[0].when <= cyc) begin
      mon_x = sb.pop_front();
      checks++;
      if (mon_x.when != cyc || mon_got !== mon_x.exp) begin
        failures++;
        $display("FAIL %s edge=%0d: got d0=%h d1=%h v0v1s0s1act=%b, want d0=%h d1=%h v0v1s0s1act=%b",
                 mon_x.name, cyc, mon_got[20:13], mon_got[12:5], mon_got[4:0],
                 mon_x.exp[20:13], mon_x.exp[12:5], mon_x.exp[4:0]);
      end
    end
  end

  task automatic send_bit(input logic b0, input logic b1);
    in_0 = b0;
    in_1 = b1;
    @(negedge clk_8f);
  endtask

  task automatic send_byte(input logic [7:0] b0, input logic [7:0] b1);
    for (int i = 7; i >= 0; i--) send_bit(b0[i], b1[i]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          b;
    logic [47:0] s0;
    logic [47:0] s1;

    reset  = 1'b1;
    enable = 1'b1;
    in_0   = 1'b0;
    in_1   = 1'b0;
    @(negedge clk_8f);

    // Reset held with random lane data
    b = cyc;
    expect_at(b + 2, "reset_hold_a", ZERO);
    expect_at(b + 5, "reset_hold_b", ZERO);
    expect_at(b + 8, "reset_hold_c", ZERO);
    for (int i = 0; i < 8; i++) send_bit(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    reset = 1'b0;

    // Lock on BC x4, data, idle comma, then enable drop mid-byte
    b = cyc;
    expect_at(b + 8,  "lock_first_comma", ZERO);
    expect_at(b + 31, "lock_not_yet",     ZERO);
    expect_at(b + 32, "lock_edge",        vec(8'h00, 8'h00, 5'b00111));
    expect_at(b + 39, "lock_no_data",     vec(8'h00, 8'h00, 5'b00111));
    expect_at(b + 40, "data_ff_00",       vec(8'hFF, 8'h00, 5'b11111));
    expect_at(b + 47, "data_ff_00_hold",  vec(8'hFF, 8'h00, 5'b11111));
    expect_at(b + 48, "data_ee",          vec(8'hEE, 8'hEE, 5'b11111));
    expect_at(b + 56, "idle_comma",       vec(8'hBC, 8'hBC, 5'b00111));
    expect_at(b + 63, "idle_comma_hold",  vec(8'hBC, 8'hBC, 5'b00111));
    expect_at(b + 64, "data_dd",          vec(8'hDD, 8'hDD, 5'b11111));
    expect_at(b + 68, "data_dd_midbyte",  vec(8'hDD, 8'hDD, 5'b11111));
    expect_at(b + 69, "enable_drop",      vec(8'hDD, 8'hDD, 5'b00000));
    expect_at(b + 71, "enable_low_hold",  vec(8'hDD, 8'hDD, 5'b00000));
    repeat (4) send_byte(8'hBC, 8'hBC);
    send_byte(8'hFF, 8'h00);
    send_byte(8'hEE, 8'hEE);
    send_byte(8'hBC, 8'hBC);
    send_byte(8'hDD, 8'hDD);
    send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b0);
    enable = 1'b0;
    repeat (3) send_bit(1'b1, 1'b1);
    enable = 1'b1;

    // Re-enable: data before fresh commas is not valid, relock needs BC x4
    b = cyc;
    expect_at(b + 8,  "reenable_no_lock",  vec(8'hDD, 8'hDD, 5'b00000));
    expect_at(b + 39, "relock_not_yet",    vec(8'hDD, 8'hDD, 5'b00000));
    expect_at(b + 40, "relock_edge",       vec(8'hDD, 8'hDD, 5'b00111));
    expect_at(b + 47, "relock_hold_old",   vec(8'hDD, 8'hDD, 5'b00111));
    expect_at(b + 48, "relock_data_77",    vec(8'h77, 8'h77, 5'b11111));
    send_byte(8'h55, 8'h55);
    repeat (4) send_byte(8'hBC, 8'hBC);
    send_byte(8'h77, 8'h77);

    // Reset pulse mid-byte while ACTIVE
    repeat (3) send_bit(1'b0, 1'b1);
    b = cyc;
    reset = 1'b1;
    expect_at(b + 1, "reset_pulse_a", ZERO);
    expect_at(b + 2, "reset_pulse_b", ZERO);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    reset = 1'b0;

    // Broken lock: BC x2, AA, BC x4
    b = cyc;
    expect_at(b + 16, "broken_two_commas", ZERO);
    expect_at(b + 24, "broken_aa",         ZERO);
    expect_at(b + 40, "broken_no_stale",   ZERO);
    expect_at(b + 48, "broken_no_stale_b", ZERO);
    expect_at(b + 55, "broken_not_yet",    ZERO);
    expect_at(b + 56, "broken_lock_edge",  vec(8'h00, 8'h00, 5'b00111));
    send_byte(8'hBC, 8'hBC);
    send_byte(8'hBC, 8'hBC);
    send_byte(8'hAA, 8'hAA);
    repeat (4) send_byte(8'hBC, 8'hBC);

    // Second reset pulse mid-byte
    repeat (5) send_bit(1'b1, 1'b1);
    b = cyc;
    reset = 1'b1;
    expect_at(b + 1, "reset_pulse2", ZERO);
    send_bit(1'b0, 1'b0);
    reset = 1'b0;

    // Misaligned lane1: 3 junk bits ahead of its commas
    s0 = {8'hBC, 8'hBC, 8'hBC, 8'hBC, 8'h12, 8'hBC};
    s1 = {3'b101, 8'hBC, 8'hBC, 8'hBC, 8'hBC, 8'h99, 5'b10111};
    b = cyc;
    expect_at(b + 31, "mis_none_locked", ZERO);
    expect_at(b + 32, "mis_lane0_lock",  vec(8'h00, 8'h00, 5'b00100));
    expect_at(b + 34, "mis_lane1_wait",  vec(8'h00, 8'h00, 5'b00100));
    expect_at(b + 35, "mis_lane1_lock",  vec(8'h00, 8'h00, 5'b00111));
    expect_at(b + 40, "mis_lane0_data",  vec(8'h12, 8'h00, 5'b10111));
    expect_at(b + 43, "mis_lane1_99",    vec(8'h12, 8'h99, 5'b11111));
    expect_at(b + 48, "mis_lane0_idle",  vec(8'hBC, 8'h99, 5'b01111));
    for (int i = 47; i >= 0; i--) send_bit(s0[i], s1[i]);

    repeat (3) @(negedge clk_8f);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending entries, want 0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
